boot_loader_ctrl: RTL and testbench
===================================

# boot_loader_ctrl

Boot sequencer that owns the core's `boot_up` line and the instruction-memory write port during power-on. It accepts a program image as a valid/ready word stream and writes it to IMEM from address 0. It holds the PC in its load state while loading, then releases it and confirms that the PC has entered its run state. It sits between the host/debug link and the fetch stage, alongside the PC register.

## Interface
- `IMEM_AW`, default 10: IMEM word-address width; maximum image is 2^IMEM_AW words.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a load; sampled in IDLE and ERR only.
- `len` in IMEM_AW+1: image length in words; sampled with `start`.
- `s_valid` in 1: stream word valid.
- `s_data` in 32: stream word.
- `s_ready` out 1: stream ready; transfer when `s_valid & s_ready`.
- `imem_we` out 1: IMEM write enable.
- `imem_addr` out IMEM_AW: IMEM word address.
- `imem_wdata` out 32: IMEM write data.
- `boot_up` out 1: drives the PC's boot input; high holds the PC in load.
- `PC_running` in 1: PC reports run state.
- `busy` out 1: state is LOAD, CHECK or RELEASE.
- `done` out 1: level; image loaded and PC running.
- `err` out 1: level; load failed.

## Operation
- States: IDLE, LOAD, CHECK (only with the macro), RELEASE, DONE, ERR.
- IDLE:
  - `start` with 1 ≤ `len` ≤ 2^IMEM_AW → LOAD. Latch `len`; clear the word counter `cnt` and the checksum.
  - `start` with `len` out of range → ERR.
- LOAD:
  - `s_ready`=1.
  - Each transfer writes `s_data` to address `cnt`, then increments `cnt`.
  - The transfer with `cnt == len-1` → CHECK (macro) or RELEASE.
  - `s_valid` low: wait indefinitely; no timeout.
- CHECK: `s_ready`=1. The next transfer is compared with the checksum; match → RELEASE, mismatch → ERR. No IMEM write for this word.
- RELEASE: `boot_up`=0; wait for `PC_running`=1 → DONE.
- DONE:
  - Terminal; `start` is ignored.
  - A new load requires `rst`, because the PC cannot re-enter load from run.
- ERR:
  - `boot_up` stays 1, so the core stays held.
  - `start` with valid `len` → LOAD (retry, counters cleared); invalid `len` → stays ERR.
- Output decode (Moore, from registered state):
  - `boot_up` = LOAD | CHECK | ERR.
  - `s_ready` = LOAD | CHECK.
  - `busy` = LOAD | CHECK | RELEASE.
  - `done` = DONE.
  - `err` = ERR.
- `start` in LOAD/CHECK/RELEASE is ignored.
- Checksum: 32-bit wrapping sum of all image words.

## Timing
- Reset values: state IDLE; `s_ready`, `imem_we`, `boot_up`, `busy`, `done`, `err` = 0; `imem_addr`, `imem_wdata` = 0; `cnt` = 0.
- `start` in cycle N → `boot_up`/`s_ready` high in cycle N+1.
- IMEM write port is registered: a transfer in cycle T produces `imem_we`=1 with that word's address and data in cycle T+1. `imem_we`=0 in all other cycles.
- Throughput: one word per cycle with `s_valid` held high.
- After the final image transfer in cycle T (no macro): RELEASE and `boot_up`=0 in T+1, which is also the cycle of the last IMEM write. The PC reports `PC_running` in T+2, DONE in T+3. IMEM is complete before the first fetch.
- `len` = 2^IMEM_AW: the counter wraps to 0 only after the transition; no extra write.
- `rst` mid-load: immediate return to IDLE, `boot_up`=0. A partial image in IMEM is not cleared.

## Configuration
- `BOOT_CKSUM_EN` defined: CHECK state exists. The stream carries `len` image words plus one checksum word; a mismatch → ERR.
- Undefined: no CHECK state, no adder; LOAD → RELEASE directly; stream carries exactly `len` words.

## Structure
- Shared package: state encoding constants (IDLE..ERR) and the default `IMEM_AW`, reused by the IMEM and top level.
- Single module. No sub-module is warranted; the checksum is one accumulator register inside the `BOOT_CKSUM_EN` guard.

## Test plan
- Reset, then `start` with `len`=4 and back-to-back words A0..A3:
  - IMEM writes to addresses 0..3 on consecutive cycles, each one cycle after its transfer.
  - `boot_up` falls the cycle after the last transfer; `done`=1 two cycles later.
- `len`=3 with `s_valid` toggling every other cycle: only handshaken words are written; addresses 0,1,2 in order; no duplicate writes.
- `start` with `len`=0 and with `len`=2^IMEM_AW+1: ERR, `err`=1, `boot_up`=1, no writes. Then `start` with `len`=1 → clean load → DONE.
- `BOOT_CKSUM_EN`, `len`=2, words 0xFFFF_FFFF and 0x2:
  - Checksum word 0x1 → DONE.
  - Checksum word 0x0 → ERR with `boot_up` held high.
- `rst` asserted after the 2nd of 5 words: next cycle IDLE, all outputs at reset values; a following full load succeeds.
- `start` pulsed in DONE and in LOAD: ignored; `cnt` and state are unchanged.

Source files
------------

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: state encoding and default IMEM geometry.
package boot_loader_ctrl_pkg;

    localparam int unsigned IMEM_AW_DEF = 10;
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: streams a program image into IMEM, holds then releases the PC.
// Optional trailing checksum word verified when BOOT_CKSUM_EN is defined.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_AW = IMEM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW:0]   len,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               boot_up,
    input  logic               PC_running,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t               state_q, state_d;
    logic [IMEM_AW-1:0]   cnt_q, cnt_d;
    logic [IMEM_AW-1:0]   last_q, last_d;
    logic                 imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]    imem_wdata_q, imem_wdata_d;
    logic                 s_ready_q, s_ready_d;
    logic                 boot_up_q, boot_up_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
`ifdef BOOT_CKSUM_EN
    logic [DATA_W-1:0]    cksum_q, cksum_d;
`endif

    logic xfer;
    logic len_ok;

    assign xfer   = s_valid & s_ready_q;
    // Legal lengths are 1 .. 2^IMEM_AW inclusive.
    assign len_ok = (len != '0) && (!len[IMEM_AW] || (len[IMEM_AW-1:0] == '0));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef BOOT_CKSUM_EN
        cksum_d      = cksum_q;
`endif

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        last_d  = IMEM_AW'(len - (IMEM_AW+1)'(1));
`ifdef BOOT_CKSUM_EN
                        cksum_d = '0;
`endif
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q;
                    imem_wdata_d = s_data;
                    // Counter wraps to 0 on a full-size image; the state change ends the load.
                    cnt_d        = cnt_q + IMEM_AW'(1);
`ifdef BOOT_CKSUM_EN
                    cksum_d      = cksum_q + s_data;
                    if (cnt_q == last_q) state_d = ST_CHECK;
`else
                    if (cnt_q == last_q) state_d = ST_RELEASE;
`endif
                end
            end
`ifdef BOOT_CKSUM_EN
            ST_CHECK: begin
                if (xfer) state_d = (s_data == cksum_q) ? ST_RELEASE : ST_ERR;
            end
`endif
            ST_RELEASE: begin
                if (PC_running) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moore outputs registered alongside the state they decode.
        s_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        boot_up_d = (state_d == ST_LOAD) || (state_d == ST_CHECK) || (state_d == ST_ERR);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_CHECK) || (state_d == ST_RELEASE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            s_ready_q    <= 1'b0;
            boot_up_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef BOOT_CKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            s_ready_q    <= s_ready_d;
            boot_up_q    <= boot_up_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef BOOT_CKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign boot_up    = boot_up_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl with a small PC model and an IMEM write log.
module tb_boot_loader_ctrl;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          boot_up;
    logic          pc_running;
    logic          busy;
    logic          done;
    logic          err;

    boot_loader_ctrl #(.IMEM_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .boot_up    (boot_up),
        .PC_running (pc_running),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // PC model: enters load while boot_up is high, runs once boot_up drops after that.
    logic pc_loaded;
    always @(posedge clk) begin
        if (rst) begin
            pc_loaded  <= 1'b0;
            pc_running <= 1'b0;
        end else begin
            if (boot_up) pc_loaded <= 1'b1;
            if (pc_loaded && !boot_up) pc_running <= 1'b1;
        end
    end

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t wlog[$];
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (imem_we) wlog.push_back('{cyc, imem_addr, imem_wdata});

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0;
        step();
        rst = 1'b0;
        wlog.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, {s_ready, imem_we, boot_up, busy, done, err, imem_addr, imem_wdata}, '0);
    endtask

    task automatic pulse_start(input int unsigned l);
        start = 1'b1; len = (AW+1)'(l);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !done; i++) step();
        check_eq(tag, done, 1);
    endtask

    logic [31:0] a_words [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
    logic [31:0] b_words [3] = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003};

    initial begin
        int c_rel;
        rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
        step();
        check_reset_outs("reset_vals");
        do_reset();

        // Back-to-back load of four words.
        pulse_start(4);
        check_eq("t1_boot_up_start", boot_up, 1);
        check_eq("t1_s_ready_start", s_ready, 1);
        check_eq("t1_busy_start", busy, 1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = a_words[i];
            step();
        end
        s_valid = 1'b0;
        c_rel = cyc;
        check_eq("t1_boot_up_release", boot_up, 0);
        check_eq("t1_busy_release", busy, 1);
        check_eq("t1_last_we", imem_we, 1);
        check_eq("t1_last_addr", imem_addr, 3);
        check_eq("t1_last_data", imem_wdata, a_words[3]);
        step();
        check_eq("t1_done_early", done, 0);
        step();
        check_eq("t1_done", done, 1);
        check_eq("t1_busy_done", busy, 0);
        check_eq("t1_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            check_eq($sformatf("t1_addr%0d", i), wlog[i].addr, i);
            check_eq($sformatf("t1_data%0d", i), wlog[i].data, a_words[i]);
            check_eq($sformatf("t1_cyc%0d", i), wlog[i].cyc, c_rel - 3 + i);
        end

        // start in DONE is ignored.
        pulse_start(2);
        step();
        check_eq("done_ignore_done", done, 1);
        check_eq("done_ignore_ready", s_ready, 0);
        check_eq("done_ignore_writes", wlog.size(), 4);

        // Toggling valid with a stray start during LOAD.
        do_reset();
        pulse_start(3);
        for (int k = 0; k < 6; k++) begin
            s_valid = (k % 2 == 0);
            s_data  = (k % 2 == 0) ? b_words[k/2] : 32'hDEAD_0000;
            if (k == 1) begin start = 1'b1; len = (AW+1)'(1); end
            step();
            start = 1'b0;
        end
        s_valid = 1'b0;
        wait_done("t2_done", 10);
        check_eq("t2_nwrites", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            check_eq($sformatf("t2_addr%0d", i), wlog[i].addr, i);
            check_eq($sformatf("t2_data%0d", i), wlog[i].data, b_words[i]);
        end

        // Illegal lengths, then a retry from ERR.
        do_reset();
        pulse_start(0);
        check_eq("t3_err_len0", err, 1);
        check_eq("t3_boot_up_len0", boot_up, 1);
        check_eq("t3_ready_len0", s_ready, 0);
        pulse_start((1 << AW) + 1);
        check_eq("t3_err_lenbig", err, 1);
        check_eq("t3_busy_lenbig", busy, 0);
        check_eq("t3_nowrites", wlog.size(), 0);
        pulse_start(1);
        check_eq("t3_retry_err", err, 0);
        check_eq("t3_retry_ready", s_ready, 1);
        s_valid = 1'b1; s_data = 32'h1234_5678;
        step();
        s_valid = 1'b0;
        wait_done("t3_done", 10);
        check_eq("t3_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) check_eq("t3_data", wlog[0].data, 32'h1234_5678);

`ifdef BOOT_CKSUM_EN
        // Checksum pass and fail.
        do_reset();
        pulse_start(2);
        s_valid = 1'b1;
        s_data = 32'hFFFF_FFFF; step();
        s_data = 32'h0000_0002; step();
        s_data = 32'h0000_0001; step();
        s_valid = 1'b0;
        wait_done("ck_pass_done", 10);
        check_eq("ck_pass_writes", wlog.size(), 2);
        do_reset();
        pulse_start(2);
        s_valid = 1'b1;
        s_data = 32'hFFFF_FFFF; step();
        s_data = 32'h0000_0002; step();
        s_data = 32'h0000_0000; step();
        s_valid = 1'b0;
        check_eq("ck_fail_err", err, 1);
        check_eq("ck_fail_boot_up", boot_up, 1);
        check_eq("ck_fail_writes", wlog.size(), 2);
`endif

        // Reset in the middle of a load, then a full load.
        do_reset();
        pulse_start(5);
        s_valid = 1'b1;
        s_data = 32'h5000_0000; step();
        s_data = 32'h5000_0001; step();
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outs("t5_reset_mid");
        wlog.delete();
        pulse_start(5);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 32'h6000_0000 + i;
            step();
        end
`ifdef BOOT_CKSUM_EN
        s_data = 32'h6000_0000 * 5 + 10; step();
`endif
        s_valid = 1'b0;
        wait_done("t5_done", 10);
        check_eq("t5_nwrites", wlog.size(), 5);
        if (wlog.size() == 5) check_eq("t5_last_addr", wlog[4].addr, 4);

        // Maximum-size image.
        do_reset();
        pulse_start(1 << AW);
        begin
            logic [31:0] sum = '0;
            for (int i = 0; i < (1 << AW); i++) begin
                s_valid = 1'b1; s_data = 32'hC0DE_0000 | i;
                sum = sum + s_data;
                step();
            end
`ifdef BOOT_CKSUM_EN
            s_data = sum; step();
`endif
        end
        s_valid = 1'b0;
        wait_done("t6_done", 10);
        step();
        check_eq("t6_nwrites", wlog.size(), 1 << AW);
        if (wlog.size() == (1 << AW)) begin
            check_eq("t6_first_addr", wlog[0].addr, 0);
            check_eq("t6_last_addr", wlog[(1 << AW) - 1].addr, (1 << AW) - 1);
            check_eq("t6_last_data", wlog[(1 << AW) - 1].data, 32'hC0DE_0000 | ((1 << AW) - 1));
        end
        check_eq("t6_we_idle", imem_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
